// File: rtl/symbol_feed_ctrl.sv
// Run sequencer for the matching engine: fetches packed 2-bit symbol words,
// streams one symbol per engine accept, holds BC_mode for the run, then drains and pulses done.
module symbol_feed_ctrl #(
  parameter int WORD_W    = 32,
  parameter int LEN_W     = 16,
  parameter int DRAIN_CYC = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic              bc_cfg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              eng_ready,
  output logic              sym_valid,
  output logic [1:0]        symbol,
  output logic              BC_mode,
  output logic              busy,
  output logic [LEN_W-1:0]  sym_cnt,
  output logic              done
);

  localparam int SPW   = WORD_W / 2;
  localparam int IDX_W = $clog2(SPW);
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPW - 1);
  localparam logic [LEN_W-1:0] SPW_L    = LEN_W'(SPW);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    fetch_rem_q, fetch_rem_d;
  logic [WORD_W-1:0]   cur_q, cur_d, nxt_q, nxt_d;
  logic                cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic                bc_q, bc_d;
  logic                sym_valid_q, sym_valid_d;
  logic [1:0]          symbol_q, symbol_d;
  logic [1:0]          cur_syms [SPW];
  logic                word_take, accept;

  // fetch_rem counts symbols not yet covered by a fetched word, so in_ready stops at ceil(len/SPW)
  assign in_ready  = ((state_q == S_FILL) || (state_q == S_STREAM)) && !nxt_v_q && (fetch_rem_q != '0);
  assign word_take = in_valid && in_ready;
  assign accept    = (state_q == S_STREAM) && sym_valid_q && eng_ready;

  assign sym_valid = sym_valid_q;
  assign symbol    = symbol_q;
  assign BC_mode   = bc_q;
  assign busy      = (state_q != S_IDLE);
  assign sym_cnt   = sym_cnt_q;
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    fetch_rem_d = fetch_rem_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    cur_v_d     = cur_v_q;
    nxt_v_d     = nxt_v_q;
    idx_d       = idx_q;
    sym_cnt_d   = sym_cnt_q;
    drain_d     = drain_q;
    bc_d        = bc_q;

    if (word_take) begin
      fetch_rem_d = (fetch_rem_q > SPW_L) ? (fetch_rem_q - SPW_L) : '0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = seq_len;
          fetch_rem_d = seq_len;
          bc_d        = bc_cfg;
          sym_cnt_d   = '0;
          cur_v_d     = 1'b0;
          nxt_v_d     = 1'b0;
          idx_d       = '0;
          state_d     = (seq_len == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (word_take) begin
          cur_d   = in_data;
          cur_v_d = 1'b1;
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept) begin
          sym_cnt_d = sym_cnt_q + LEN_W'(1);
          if ((sym_cnt_q + LEN_W'(1)) == len_q) begin
            state_d = S_DRAIN;
            drain_d = DRN_W'(DRAIN_CYC);
            cur_v_d = 1'b0;
            nxt_v_d = 1'b0;
          end else if (idx_q == IDX_LAST) begin
            // last symbol of cur consumed: refill from prefetch or the incoming word with no bubble
            idx_d = '0;
            if (nxt_v_q) begin
              cur_d   = nxt_q;
              nxt_v_d = 1'b0;
            end else if (word_take) begin
              cur_d = in_data;
            end else begin
              cur_v_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (word_take) begin
              nxt_d   = in_data;
              nxt_v_d = 1'b1;
            end
          end
        end else if (word_take) begin
          if (cur_v_q) begin
            nxt_d   = in_data;
            nxt_v_d = 1'b1;
          end else begin
            cur_d   = in_data;
            cur_v_d = 1'b1;
            idx_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q <= DRN_W'(1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        bc_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cur_v_d   = 1'b0;
      nxt_v_d   = 1'b0;
      idx_d     = '0;
      bc_d      = 1'b0;
      sym_cnt_d = sym_cnt_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SPW; gi++) begin : g_sym
      assign cur_syms[gi] = cur_d[2*gi +: 2];
    end
  endgenerate

  // Output symbol registers track the next buffer state so they are valid the cycle cur holds data
  always_comb begin
    sym_valid_d = (state_d == S_STREAM) && cur_v_d;
    symbol_d    = sym_valid_d ? cur_syms[idx_d] : 2'b00;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      fetch_rem_q <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      cur_v_q     <= 1'b0;
      nxt_v_q     <= 1'b0;
      idx_q       <= '0;
      sym_cnt_q   <= '0;
      drain_q     <= '0;
      bc_q        <= 1'b0;
      sym_valid_q <= 1'b0;
      symbol_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      fetch_rem_q <= fetch_rem_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      cur_v_q     <= cur_v_d;
      nxt_v_q     <= nxt_v_d;
      idx_q       <= idx_d;
      sym_cnt_q   <= sym_cnt_d;
      drain_q     <= drain_d;
      bc_q        <= bc_d;
      sym_valid_q <= sym_valid_d;
      symbol_q    <= symbol_d;
    end
  end

endmodule

// File: tb/tb_symbol_feed_ctrl.sv
// Directed bench for symbol_feed_ctrl with WORD_W=8 (4 symbols/word), LEN_W=8, DRAIN_CYC=4.
module tb_symbol_feed_ctrl;

  logic       CLK = 1'b0;
  logic       RST, start, abort, bc_cfg, in_valid, eng_ready;
  logic [7:0] seq_len, in_data;
  logic       in_ready, sym_valid, BC_mode, busy, done;
  logic [1:0] symbol;
  logic [7:0] sym_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int bub;

  symbol_feed_ctrl #(.WORD_W(8), .LEN_W(8), .DRAIN_CYC(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .seq_len(seq_len),
    .bc_cfg(bc_cfg), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .eng_ready(eng_ready), .sym_valid(sym_valid), .symbol(symbol), .BC_mode(BC_mode),
    .busy(busy), .sym_cnt(sym_cnt), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag, input int cnt);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sym_valid"}, sym_valid, 0);
    check({tag, "_symbol"}, symbol, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_bc_mode"}, BC_mode, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sym_cnt"}, sym_cnt, cnt);
  endtask

  // One run: words[8p+:8] is word p, exp[2k+:2] is the expected k-th accepted symbol.
  task automatic run_case(input string name, input int len, input bit bc, input logic [23:0] words,
                          input logic [31:0] exp, input logic [15:0] eng_pat, input int gap_lo,
                          input int gap_hi, input int restart_cyc, output int bubbles);
    int ptr, acc, cyc, need, done_before, n;
    bit taken, accepted, stalled;
    logic [1:0] held;
    need = (len + 3) / 4;
    done_before = done_cnt;
    start = 1; seq_len = 8'(len); bc_cfg = bc;
    tick();
    start = 0; seq_len = 8'hFF; bc_cfg = ~bc;
    check({name, "_busy"}, busy, 1);
    ptr = 0; acc = 0; cyc = 0; bubbles = 0; stalled = 0; held = 2'b00;
    while (acc < len && cyc < 200) begin
      in_valid  = (cyc < gap_lo || cyc >= gap_hi) && ptr < 3;
      in_data   = (ptr < 3) ? words[8*ptr +: 8] : 8'hFF;
      eng_ready = eng_pat[cyc % 16];
      if (cyc == restart_cyc) begin
        start = 1; seq_len = 8'd2; bc_cfg = ~bc;
      end else begin
        start = 0;
      end
      check({name, "_bc_mode"}, BC_mode, bc);
      if (ptr >= need) check({name, "_in_ready_after_last"}, in_ready, 0);
      if (stalled && sym_valid) check({name, "_hold"}, symbol, held);
      if (!sym_valid) begin
        check({name, "_symbol_zero"}, symbol, 0);
        if (acc > 0) bubbles++;
      end
      accepted = sym_valid && eng_ready;
      taken    = in_valid && in_ready;
      if (accepted) begin
        check($sformatf("%s_sym%0d", name, acc), symbol, exp[2*acc +: 2]);
        check($sformatf("%s_cnt%0d", name, acc), sym_cnt, acc);
      end
      stalled = sym_valid && !eng_ready;
      held    = symbol;
      tick();
      if (taken) ptr++;
      if (accepted) acc++;
      cyc++;
    end
    start = 0; in_valid = 0; eng_ready = 0;
    check({name, "_accepts"}, acc, len);
    check({name, "_drain_sym_valid"}, sym_valid, 0);
    check({name, "_drain_in_ready"}, in_ready, 0);
    check({name, "_final_cnt"}, sym_cnt, len);
    check({name, "_words"}, ptr, need);
    wait_done(n);
    check({name, "_drain_cycles"}, n, 4);
    check({name, "_done_bc_mode"}, BC_mode, bc);
    tick();
    check_idle_outputs({name, "_post"}, len);
    check({name, "_done_pulses"}, done_cnt - done_before, 1);
    $display("[TB] run %s len=%0d bc=%0d accepts=%0d words=%0d bubbles=%0d", name, len, bc, acc, ptr, bubbles);
  endtask

  initial begin
    int done_before;
    RST = 1; start = 0; abort = 0; seq_len = 0; bc_cfg = 0;
    in_valid = 0; in_data = 0; eng_ready = 0;
    tick(); tick();
    check_idle_outputs("reset", 0);
    RST = 0;
    tick();
    $display("[TB] reset checked");

    // 1: full 8-symbol run, nothing held off, must be bubble-free
    run_case("basic", 8, 1'b1, 24'hFF_1B_E4, 32'h0000_1BE4, 16'hFFFF, 0, 0, -1, bub);
    check("basic_bubbles", bub, 0);

    // 2: 6 symbols, second word lands exactly as cur empties
    run_case("tail", 6, 1'b0, 24'hFF_B1_6C, 32'h0000_B16C, 16'hFFFF, 1, 4, -1, bub);
    check("tail_bubbles", bub, 0);

    // 3: engine backpressure plus upstream gap starving the buffers
    run_case("stall", 8, 1'b1, 24'hFF_1B_E4, 32'h0000_1BE4, 16'hAAAA, 1, 10, -1, bub);
    check("stall_bubbles", bub, 3);

    // 4: zero-length run
    done_before = done_cnt;
    start = 1; seq_len = 0; bc_cfg = 1; in_valid = 1; in_data = 8'hE4; eng_ready = 1;
    tick();
    start = 0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 1);
    check("zero_bc_mode", BC_mode, 1);
    check("zero_in_ready", in_ready, 0);
    check("zero_sym_valid", sym_valid, 0);
    check("zero_sym_cnt", sym_cnt, 0);
    tick();
    in_valid = 0; eng_ready = 0;
    check_idle_outputs("zero_post", 0);
    check("zero_done_pulses", done_cnt - done_before, 1);
    $display("[TB] run zero len=0 done_pulses=%0d", done_cnt - done_before);

    // 5: abort after three accepts, simultaneous start ignored
    done_before = done_cnt;
    start = 1; seq_len = 8; bc_cfg = 1;
    tick();
    start = 0; in_valid = 1; in_data = 8'hE4; eng_ready = 1;
    tick();
    in_data = 8'h1B;
    tick(); tick(); tick();
    check("abort_pre_cnt", sym_cnt, 3);
    abort = 1; start = 1; bc_cfg = 0; seq_len = 4;
    tick();
    abort = 0; start = 0; in_valid = 0; eng_ready = 0;
    check_idle_outputs("abort", 3);
    tick();
    check("abort_still_idle", busy, 0);
    check("abort_no_done", done_cnt - done_before, 0);
    $display("[TB] run abort at sym_cnt=3");
    run_case("fresh", 4, 1'b0, 24'hFF_FF_9C, 32'h0000_009C, 16'hFFFF, 0, 0, -1, bub);

    // 6: synchronous reset mid-stream, then a start pulse while busy
    done_before = done_cnt;
    start = 1; seq_len = 8; bc_cfg = 1;
    tick();
    start = 0; in_valid = 1; in_data = 8'hE4; eng_ready = 1;
    tick(); tick();
    RST = 1;
    tick();
    RST = 0; in_valid = 0; eng_ready = 0;
    check_idle_outputs("rst", 0);
    for (int i = 0; i < 6; i++) tick();
    check("rst_no_done", done_cnt - done_before, 0);
    $display("[TB] run reset mid-stream");
    run_case("restart", 5, 1'b1, 24'hFF_1B_E4, 32'h0000_1BE4, 16'hFFFF, 0, 0, 3, bub);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
